// File: rtl/cache_l1_controller.sv
// 4-way fully associative L1 cache controller, write-back / write-allocate,
// with true-LRU replacement, a req/ack memory port and saturating hit/miss counters.
module cache_l1_controller #(
  parameter int TAG_W  = 8,
  parameter int DATA_W = 4,
  parameter int CNT_W  = 8
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              cpu_req,
  input  logic              cpu_wren,
  input  logic [TAG_W-1:0]  cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              done,
  output logic              hit,
  output logic              mem_req,
  output logic              mem_wren,
  output logic [TAG_W-1:0]  mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ack,
  output logic [CNT_W-1:0]  hit_count,
  output logic [CNT_W-1:0]  miss_count
);

  localparam int WAYS = 4;

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] LOOKUP = 2'd1;
  localparam logic [1:0] WB     = 2'd2;
  localparam logic [1:0] FILL   = 2'd3;

  logic [1:0] state_q;

  logic              valid_q [WAYS];
  logic              dirty_q [WAYS];
  logic [1:0]        age_q   [WAYS];
  logic [TAG_W-1:0]  tag_q   [WAYS];
  logic [DATA_W-1:0] data_q  [WAYS];

  logic              req_wren_q;
  logic [TAG_W-1:0]  req_addr_q;
  logic [DATA_W-1:0] req_wdata_q;
  logic [1:0]        victim_q;

  logic              hit_any;
  logic [1:0]        hit_way;
  logic              inv_any;
  logic [1:0]        inv_way;
  logic [1:0]        old_way;
  logic [1:0]        victim;
  logic [1:0]        touch_way;
  logic [1:0]        touch_age;
  logic [1:0]        age_next [WAYS];
  logic [DATA_W-1:0] access_data;
  logic              mem_done;

  assign done     = (state_q == IDLE);
  assign mem_done = mem_req && mem_ack;

  // NOTE: every signal driven here gets a default first so no latch is inferred.
  always_comb begin
    hit_any = 1'b0;
    hit_way = 2'd0;
    inv_any = 1'b0;
    inv_way = 2'd0;
    old_way = 2'd0;
    for (int i = 0; i < WAYS; i++) begin
      if (valid_q[i] && (tag_q[i] == req_addr_q)) begin
        hit_any = 1'b1;
        hit_way = 2'(i);
      end
      if (age_q[i] == 2'd3) old_way = 2'(i);
    end
    // Scan downward so the lowest-index invalid way wins.
    for (int i = WAYS - 1; i >= 0; i--) begin
      if (!valid_q[i]) begin
        inv_any = 1'b1;
        inv_way = 2'(i);
      end
    end
    victim = inv_any ? inv_way : old_way;
  end

  // The way being touched is the hit way in LOOKUP and the chosen victim on install.
  always_comb begin
    touch_way = (state_q == LOOKUP) ? hit_way : victim_q;
    touch_age = age_q[touch_way];
    for (int i = 0; i < WAYS; i++) begin
      if (2'(i) == touch_way)
        age_next[i] = 2'd0;
      else if (age_q[i] < touch_age)
        age_next[i] = age_q[i] + 2'd1;
      else
        age_next[i] = age_q[i];
    end
    if (req_wren_q)
      access_data = req_wdata_q;
    else if (state_q == FILL)
      access_data = mem_rdata;
    else
      access_data = data_q[hit_way];
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= IDLE;
      // NOTE: the line array is tiny and reset must discard it, so it is reset like any register.
      for (int i = 0; i < WAYS; i++) begin
        valid_q[i] <= 1'b0;
        dirty_q[i] <= 1'b0;
        age_q[i]   <= 2'(i);
        tag_q[i]   <= '0;
        data_q[i]  <= '0;
      end
      req_wren_q  <= 1'b0;
      req_addr_q  <= '0;
      req_wdata_q <= '0;
      victim_q    <= 2'd0;
      cpu_rdata   <= '0;
      hit         <= 1'b0;
      mem_req     <= 1'b0;
      mem_wren    <= 1'b0;
      mem_addr    <= '0;
      mem_wdata   <= '0;
      hit_count   <= '0;
      miss_count  <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (cpu_req) begin
            req_wren_q  <= cpu_wren;
            req_addr_q  <= cpu_addr;
            req_wdata_q <= cpu_wdata;
            state_q     <= LOOKUP;
          end
        end

        LOOKUP: begin
          if (hit_any) begin
            if (req_wren_q) begin
              data_q[hit_way]  <= req_wdata_q;
              dirty_q[hit_way] <= 1'b1;
            end
            for (int i = 0; i < WAYS; i++) age_q[i] <= age_next[i];
            cpu_rdata <= access_data;
            hit       <= 1'b1;
            if (hit_count != '1) hit_count <= hit_count + CNT_W'(1);
            state_q   <= IDLE;
          end else begin
            victim_q <= victim;
            if (valid_q[victim] && dirty_q[victim]) begin
              mem_wren  <= 1'b1;
              mem_addr  <= tag_q[victim];
              mem_wdata <= data_q[victim];
              state_q   <= WB;
            end else begin
              mem_wren  <= 1'b0;
              mem_addr  <= req_addr_q;
              state_q   <= FILL;
            end
          end
        end

        WB: begin
          if (mem_done) begin
            // Dropping mem_req here guarantees a low cycle before the fill request.
            mem_req  <= 1'b0;
            mem_wren <= 1'b0;
            mem_addr <= req_addr_q;
            state_q  <= FILL;
          end else begin
            mem_req  <= 1'b1;
          end
        end

        FILL: begin
          if (mem_done) begin
            mem_req            <= 1'b0;
            valid_q[victim_q]  <= 1'b1;
            tag_q[victim_q]    <= req_addr_q;
            data_q[victim_q]   <= access_data;
            dirty_q[victim_q]  <= req_wren_q;
            for (int i = 0; i < WAYS; i++) age_q[i] <= age_next[i];
            cpu_rdata          <= access_data;
            hit                <= 1'b0;
            if (miss_count != '1) miss_count <= miss_count + CNT_W'(1);
            state_q            <= IDLE;
          end else begin
            mem_req <= 1'b1;
          end
        end

        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_cache_l1_controller.sv
// Directed, table-driven bench for cache_l1_controller; the bench acts as main memory
// and compares against hand-computed expectations.
module tb_cache_l1_controller;

  logic       clock = 1'b0;
  logic       reset;
  logic       cpu_req;
  logic       cpu_wren;
  logic [7:0] cpu_addr;
  logic [3:0] cpu_wdata;
  logic [3:0] cpu_rdata;
  logic       done;
  logic       hit;
  logic       mem_req;
  logic       mem_wren;
  logic [7:0] mem_addr;
  logic [3:0] mem_wdata;
  logic [3:0] mem_rdata;
  logic       mem_ack;
  logic [7:0] hit_count;
  logic [7:0] miss_count;

  cache_l1_controller #(.TAG_W(8), .DATA_W(4), .CNT_W(8)) dut (
    .clock      (clock),
    .reset      (reset),
    .cpu_req    (cpu_req),
    .cpu_wren   (cpu_wren),
    .cpu_addr   (cpu_addr),
    .cpu_wdata  (cpu_wdata),
    .cpu_rdata  (cpu_rdata),
    .done       (done),
    .hit        (hit),
    .mem_req    (mem_req),
    .mem_wren   (mem_wren),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_rdata  (mem_rdata),
    .mem_ack    (mem_ack),
    .hit_count  (hit_count),
    .miss_count (miss_count)
  );

  always #5 clock = ~clock;

  int checks = 0;
  int errors = 0;

  int         txn_n;
  logic       txn_wren  [2];
  logic [7:0] txn_addr  [2];
  logic [3:0] txn_wdata [2];
  int         gap_low;
  int         low_cycles;

  typedef struct {
    logic       rst;
    logic       wr;
    logic [7:0] addr;
    logic [3:0] wdata;
    logic [3:0] fill;
    int         stall;
    logic [3:0] exp_rdata;
    logic       exp_hit;
    int         exp_txns;
    logic [7:0] exp_wb_addr;
    logic [3:0] exp_wb_data;
    logic [7:0] exp_hits;
    logic [7:0] exp_misses;
  } vec_t;

  vec_t vecs [18];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic logic lru_perm();
    logic [3:0] seen;
    seen = '0;
    for (int i = 0; i < 4; i++) seen[dut.age_q[i]] = 1'b1;
    return seen == 4'hF;
  endfunction

  task automatic do_reset();
    @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
  endtask

  // One CPU access; the bench answers every memory request after 'stall' cycles.
  task automatic do_access(input logic wr, input logic [7:0] a, input logic [3:0] wd,
                           input logic [3:0] fill, input int stall);
    int guard;
    int wait_cnt;
    logic acked;
    guard = 0;
    while (!done && guard < 50) begin
      @(negedge clock);
      guard++;
    end
    check("ready", done, 1);
    cpu_req   = 1'b1;
    cpu_wren  = wr;
    cpu_addr  = a;
    cpu_wdata = wd;
    @(negedge clock);
    cpu_req    = 1'b0;
    txn_n      = 0;
    gap_low    = 0;
    low_cycles = 0;
    wait_cnt   = 0;
    acked      = 1'b0;
    guard      = 0;
    while (!done && guard < 200) begin
      low_cycles++;
      if (acked && !mem_req && txn_n == 1) gap_low++;
      if (mem_ack) begin
        mem_ack = 1'b0;
      end else if (mem_req) begin
        if (wait_cnt == stall) begin
          if (txn_n < 2) begin
            txn_wren[txn_n]  = mem_wren;
            txn_addr[txn_n]  = mem_addr;
            txn_wdata[txn_n] = mem_wdata;
          end
          txn_n++;
          mem_ack   = 1'b1;
          mem_rdata = fill;
          wait_cnt  = 0;
          acked     = 1'b1;
        end else begin
          wait_cnt++;
        end
      end
      @(negedge clock);
      guard++;
    end
    mem_ack = 1'b0;
    check("done_return", done, 1);
  endtask

  initial begin
    reset     = 1'b1;
    cpu_req   = 1'b0;
    cpu_wren  = 1'b0;
    cpu_addr  = '0;
    cpu_wdata = '0;
    mem_rdata = '0;
    mem_ack   = 1'b0;

    // rst, wr, addr, wdata, fill, stall, rdata, hit, txns, wb_addr, wb_data, hits, misses
    vecs[0]  = '{1'b1, 1'b0, 8'd100, 4'd0, 4'd5,  3, 4'd5,  1'b0, 1, 8'd0,   4'd0, 8'd0, 8'd1};
    vecs[1]  = '{1'b0, 1'b0, 8'd100, 4'd0, 4'd0,  0, 4'd5,  1'b1, 0, 8'd0,   4'd0, 8'd1, 8'd1};
    vecs[2]  = '{1'b1, 1'b1, 8'd100, 4'd9, 4'd3,  1, 4'd9,  1'b0, 1, 8'd0,   4'd0, 8'd0, 8'd1};
    vecs[3]  = '{1'b0, 1'b0, 8'd101, 4'd0, 4'd1,  0, 4'd1,  1'b0, 1, 8'd0,   4'd0, 8'd0, 8'd2};
    vecs[4]  = '{1'b0, 1'b0, 8'd102, 4'd0, 4'd2,  2, 4'd2,  1'b0, 1, 8'd0,   4'd0, 8'd0, 8'd3};
    vecs[5]  = '{1'b0, 1'b0, 8'd103, 4'd0, 4'd4,  0, 4'd4,  1'b0, 1, 8'd0,   4'd0, 8'd0, 8'd4};
    vecs[6]  = '{1'b0, 1'b0, 8'd104, 4'd0, 4'd7,  1, 4'd7,  1'b0, 2, 8'd100, 4'd9, 8'd0, 8'd5};
    vecs[7]  = '{1'b0, 1'b0, 8'd100, 4'd0, 4'd6,  0, 4'd6,  1'b0, 1, 8'd0,   4'd0, 8'd0, 8'd6};
    vecs[8]  = '{1'b1, 1'b0, 8'd100, 4'd0, 4'd10, 0, 4'd10, 1'b0, 1, 8'd0,   4'd0, 8'd0, 8'd1};
    vecs[9]  = '{1'b0, 1'b0, 8'd101, 4'd0, 4'd11, 0, 4'd11, 1'b0, 1, 8'd0,   4'd0, 8'd0, 8'd2};
    vecs[10] = '{1'b0, 1'b0, 8'd102, 4'd0, 4'd12, 0, 4'd12, 1'b0, 1, 8'd0,   4'd0, 8'd0, 8'd3};
    vecs[11] = '{1'b0, 1'b0, 8'd103, 4'd0, 4'd13, 0, 4'd13, 1'b0, 1, 8'd0,   4'd0, 8'd0, 8'd4};
    vecs[12] = '{1'b0, 1'b0, 8'd100, 4'd0, 4'd0,  0, 4'd10, 1'b1, 0, 8'd0,   4'd0, 8'd1, 8'd4};
    vecs[13] = '{1'b0, 1'b0, 8'd104, 4'd0, 4'd14, 0, 4'd14, 1'b0, 1, 8'd0,   4'd0, 8'd1, 8'd5};
    vecs[14] = '{1'b0, 1'b0, 8'd101, 4'd0, 4'd11, 1, 4'd11, 1'b0, 1, 8'd0,   4'd0, 8'd1, 8'd6};
    vecs[15] = '{1'b0, 1'b0, 8'd100, 4'd0, 4'd0,  0, 4'd10, 1'b1, 0, 8'd0,   4'd0, 8'd2, 8'd6};
    vecs[16] = '{1'b0, 1'b1, 8'd104, 4'd3, 4'd0,  0, 4'd3,  1'b1, 0, 8'd0,   4'd0, 8'd3, 8'd6};
    vecs[17] = '{1'b0, 1'b0, 8'd104, 4'd0, 4'd0,  0, 4'd3,  1'b1, 0, 8'd0,   4'd0, 8'd4, 8'd6};

    repeat (2) @(negedge clock);
    reset = 1'b0;

    check("rst_done",       done,       1);
    check("rst_hit",        hit,        0);
    check("rst_rdata",      cpu_rdata,  0);
    check("rst_mem_req",    mem_req,    0);
    check("rst_mem_wren",   mem_wren,   0);
    check("rst_mem_addr",   mem_addr,   0);
    check("rst_mem_wdata",  mem_wdata,  0);
    check("rst_hit_count",  hit_count,  0);
    check("rst_miss_count", miss_count, 0);
    check("rst_valid0",     dut.valid_q[0], 0);
    check("rst_age3",       dut.age_q[3],   3);

    for (int i = 0; i < 18; i++) begin
      if (vecs[i].rst) do_reset();
      do_access(vecs[i].wr, vecs[i].addr, vecs[i].wdata, vecs[i].fill, vecs[i].stall);
      check($sformatf("v%0d_rdata", i),  cpu_rdata,  vecs[i].exp_rdata);
      check($sformatf("v%0d_hit", i),    hit,        vecs[i].exp_hit);
      check($sformatf("v%0d_txns", i),   txn_n,      vecs[i].exp_txns);
      check($sformatf("v%0d_hits", i),   hit_count,  vecs[i].exp_hits);
      check($sformatf("v%0d_misses", i), miss_count, vecs[i].exp_misses);
      check($sformatf("v%0d_lru", i),    lru_perm(), 1);
      if (vecs[i].exp_hit)
        check($sformatf("v%0d_lat", i), low_cycles, 1);
      if (vecs[i].exp_txns == 1 && txn_n == 1) begin
        check($sformatf("v%0d_fill_wren", i), txn_wren[0], 0);
        check($sformatf("v%0d_fill_addr", i), txn_addr[0], vecs[i].addr);
      end
      if (vecs[i].exp_txns == 2 && txn_n == 2) begin
        check($sformatf("v%0d_wb_wren", i),   txn_wren[0],  1);
        check($sformatf("v%0d_wb_addr", i),   txn_addr[0],  vecs[i].exp_wb_addr);
        check($sformatf("v%0d_wb_data", i),   txn_wdata[0], vecs[i].exp_wb_data);
        check($sformatf("v%0d_fill_wren", i), txn_wren[1],  0);
        check($sformatf("v%0d_fill_addr", i), txn_addr[1],  vecs[i].addr);
        check($sformatf("v%0d_gap", i),       gap_low >= 1, 1);
      end
      if (i == 0) begin
        check("way0_valid", dut.valid_q[0], 1);
        check("way0_tag",   dut.tag_q[0],   100);
        check("way0_age",   dut.age_q[0],   0);
      end
      if (i == 13) check("victim_was_101", dut.tag_q[1], 104);
    end

    // Stalled fill: spurious ack before mem_req, ignored cpu_req pulses, then reset.
    @(negedge clock);
    cpu_req  = 1'b1;
    cpu_wren = 1'b0;
    cpu_addr = 8'd50;
    @(negedge clock);
    cpu_req = 1'b0;
    @(negedge clock);
    mem_ack = 1'b1;
    @(negedge clock);
    mem_ack = 1'b0;
    check("stall_req_up",  mem_req,  1);
    check("stall_in_fill", done,     0);
    for (int k = 0; k < 10; k++) begin
      cpu_req  = k[0];
      cpu_addr = 8'd77;
      @(negedge clock);
      check($sformatf("stall%0d_req", k),  mem_req,  1);
      check($sformatf("stall%0d_addr", k), mem_addr, 50);
      check($sformatf("stall%0d_done", k), done,     0);
    end
    cpu_req = 1'b0;
    reset   = 1'b1;
    @(negedge clock);
    check("mid_rst_mem_req", mem_req,    0);
    check("mid_rst_done",    done,       1);
    check("mid_rst_hits",    hit_count,  0);
    check("mid_rst_misses",  miss_count, 0);
    for (int w = 0; w < 4; w++)
      check($sformatf("mid_rst_valid%0d", w), dut.valid_q[w], 0);
    reset = 1'b0;

    // Saturation of the hit counter.
    do_access(1'b0, 8'd50, 4'd0, 4'd8, 0);
    check("sat_first_miss", miss_count, 1);
    for (int k = 1; k <= 300; k++) begin
      do_access(1'b0, 8'd50, 4'd0, 4'd0, 0);
      if (k == 254) check("sat_254", hit_count, 254);
      if (k == 255) check("sat_255", hit_count, 255);
    end
    check("sat_hits",   hit_count,  255);
    check("sat_misses", miss_count, 1);
    check("sat_rdata",  cpu_rdata,  8);
    check("sat_hit",    hit,        1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/cache_l1_controller.md
Name: cache_l1_controller

Overview:
- Sequences the 4-entry fully associative L1 cache, write-back/write-allocate, between the CPU port and a slower main memory with a req/ack handshake.
- Owns the 4 line registers: valid[15], dirty[14], LRU age[13:12], tag[11:4], data[3:0].
- Owns the miss/hit FSM, LRU replacement and the hit/miss statistics counters.

Parameters:
TAG_W, 8, tag and memory address width (line address = tag; one 4-bit word per line)
DATA_W, 4, data word width
CNT_W, 8, width of the saturating hit/miss counters

Ports:
clock  in  1  system clock, all state updates on rising edge
reset  in  1  synchronous, active-high; one clock, no other clock/reset domains
cpu_req  in  1  access request, sampled only while done=1
cpu_wren  in  1  1=write, 0=read
cpu_addr  in  TAG_W  access address (tag)
cpu_wdata  in  DATA_W  write data
cpu_rdata  out  DATA_W  read result, valid when done returns high
done  out  1  controller idle/ready; low while an access is in flight
hit  out  1  registered: 1 if the last completed access hit
mem_req  out  1  memory transaction request
mem_wren  out  1  1=writeback, 0=fill read
mem_addr  out  TAG_W  memory address
mem_wdata  out  DATA_W  writeback data
mem_rdata  in  DATA_W  fill data, valid with mem_ack
mem_ack  in  1  memory completes the current transaction
hit_count  out  CNT_W  completed hits, saturating
miss_count  out  CNT_W  completed misses, saturating

Behaviour:
- Reset values:
  - Lines: valid=0, dirty=0, tag=0, data=0; LRU ages way0..3 = 0,1,2,3.
  - Outputs: done=1, hit=0, cpu_rdata=0, mem_req=0, mem_wren=0, mem_addr=0, mem_wdata=0, counters=0.
  - FSM: IDLE.
- FSM states: IDLE, LOOKUP, WB, FILL.
- IDLE (done=1): on cpu_req=1, latch addr/wren/wdata, go to LOOKUP; done=0 from the next cycle.
- LOOKUP:
  - Hit = some way with valid=1 and tag==latched addr.
  - On hit:
    - Read: cpu_rdata=line data.
    - Write: line data=wdata, dirty=1, cpu_rdata=wdata.
    - LRU update; hit=1; hit_count+1; go to IDLE.
  - Hit latency: done high again 2 edges after the edge that sampled cpu_req.
  - On miss, pick the victim:
    - First choice: lowest-index invalid way.
    - Otherwise: the way with age 3.
  - Victim valid and dirty -> WB; else -> FILL.
- WB:
  - Drives mem_wren=1, mem_addr=victim tag, mem_wdata=victim data.
  - On the edge mem_ack=1 is sampled, go to FILL.
- FILL:
  - Drives mem_wren=0, mem_addr=latched addr.
  - On the edge mem_ack=1 is sampled:
    - Install the line: valid=1, tag=addr, data=mem_rdata, dirty=0.
    - Complete the access as on a hit, but overwriting the fill data for writes.
    - hit=0; miss_count+1; go to IDLE.
- mem_req handshake:
  - Registered; rises the cycle after entering WB or FILL.
  - Held high with address/data stable until mem_ack is sampled; falls on that same edge.
  - At least one low cycle between the WB and FILL transactions.
- LRU rule, on access or install of way w with age a:
  - Every way with age < a increments; w becomes 0.
  - Ages stay a permutation of 0..3 at all times.
- Boundary conditions:
  - Counters saturate at 2^CNT_W-1; no wrap.
  - cpu_req while done=0 is ignored; no queuing.
  - mem_ack while mem_req=0 is ignored.
  - Unbounded memory stall: remain in WB/FILL with outputs stable indefinitely.
  - Write miss to a dirty victim performs writeback, then fill, then merge; 2 memory transactions.
- Reset mid-operation (any state):
  - Next edge: IDLE, mem_req=0, done=1.
  - All lines invalidated, dirty data discarded, counters cleared.

Test Plan:
1. Reset; read addr 100, memory returns 5 after 3 cycles -> one FILL, mem_addr=100, mem_wren=0; cpu_rdata=5, hit=0, miss_count=1; way0 valid, tag 100, age 0.
2. Then read 100 -> done low exactly one cycle, no mem_req; cpu_rdata=5, hit=1, hit_count=1.
3. Reset; write 100 data 9 (miss), read 101, 102, 103 (fills 2, 3, 4); read 104 -> WB with mem_addr=100, mem_wdata=9, mem_wren=1; then FILL of 104 into way0; mem_req low ≥1 cycle between the two transactions; miss_count=5.
4. Fill 100..103 clean, read 100 (hit), read 104 -> victim is the line holding 101; no writeback; LRU ages remain a permutation.
5. During FILL, hold mem_ack=0 for 10 cycles and pulse cpu_req -> mem_req stays 1, mem_addr stable, done=0, pulses ignored. Then assert reset -> next cycle mem_req=0, done=1, all lines invalid, counters 0.
6. 300 hits to one resident line -> hit_count saturates at 255; miss_count unchanged.
